// File: rtl/ifetch_wide.sv
// N-wide fetch: one aligned block per cycle, masked by start offset and first predicted-taken lane.
// Latency 0 (combinational Icache hit to packet); a stall parks the block in a one-entry hold buffer.
// Backpressure: stall never blocks the Icache; the Icache request is dropped while a block is held.
`ifndef XLEN
`define XLEN 32
`endif

package ifetch_pkg;
    typedef struct packed {
        logic [31:0]       inst;
        logic [`XLEN-1:0]  PC;
        logic [`XLEN-1:0]  NPC;
        logic              valid;
    } IF_ID_PACKET;
endpackage

module ifetch_wide
    import ifetch_pkg::*;
#(
    parameter  int FETCH_WIDTH = 4,
    localparam int BLOCK_BYTES = 4 * FETCH_WIDTH,
    localparam int OFS_BITS    = $clog2(FETCH_WIDTH)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      squash_from_retire_in,
    input  logic [`XLEN-1:0]          squashed_new_PC_in,
    input  logic                      Icache2proc_valid_in,
    input  logic [32*FETCH_WIDTH-1:0] Icache2proc_data_in,
    input  logic [FETCH_WIDTH-1:0]    bp_taken,
    input  logic [`XLEN-1:0]          bp_target [FETCH_WIDTH],
    output logic [`XLEN-1:0]          proc2Icache_addr_out,
    output logic                      proc2Icache_req_out,
    output IF_ID_PACKET               if_packet_out [FETCH_WIDTH]
);
    localparam int XW = `XLEN;

    typedef enum logic {S_FETCH, S_HOLD} state_t;

    state_t                    state, state_nxt;
    logic [XW-1:0]             pc_reg, pc_nxt;
    logic                      hold_load;

    logic [32*FETCH_WIDTH-1:0] hold_data;
    logic [FETCH_WIDTH-1:0]    hold_taken;
    logic [XW-1:0]             hold_target [FETCH_WIDTH];
    logic [OFS_BITS-1:0]       hold_ofs;
    logic [XW-1:0]             hold_base;

    logic [XW-1:0]             fetch_base;
    logic [OFS_BITS-1:0]       fetch_ofs;
    logic                      in_hold;
    logic                      src_vld;
    logic [32*FETCH_WIDTH-1:0] cur_data;
    logic [FETCH_WIDTH-1:0]    cur_taken;
    logic [XW-1:0]             cur_target [FETCH_WIDTH];
    logic [OFS_BITS-1:0]       cur_ofs;
    logic [XW-1:0]             cur_base;
    logic                      blocked;
    logic                      live;
    logic [XW-1:0]             next_pc;

    assign fetch_base           = pc_reg & ~XW'(BLOCK_BYTES - 1);
    assign fetch_ofs            = pc_reg[OFS_BITS+1:2];
    assign in_hold              = (state == S_HOLD);
    assign proc2Icache_addr_out = fetch_base;
    assign proc2Icache_req_out  = (state == S_FETCH);

    // Lane masking and per-lane packet build from either the live Icache block or the held one.
    always_comb begin
        src_vld   = in_hold ? 1'b1       : Icache2proc_valid_in;
        cur_data  = in_hold ? hold_data  : Icache2proc_data_in;
        cur_taken = in_hold ? hold_taken : bp_taken;
        cur_ofs   = in_hold ? hold_ofs   : fetch_ofs;
        cur_base  = in_hold ? hold_base  : fetch_base;
        blocked   = 1'b0;
        live      = 1'b0;
        next_pc   = fetch_base + XW'(BLOCK_BYTES);
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            cur_target[i] = in_hold ? hold_target[i] : bp_target[i];
            live = src_vld && (i >= int'(cur_ofs)) && !blocked;
            if_packet_out[i].inst  = cur_data[32*i +: 32];
            if_packet_out[i].PC    = cur_base + XW'(4 * i);
            if_packet_out[i].NPC   = cur_taken[i] ? cur_target[i] : cur_base + XW'(4 * i + 4);
            if_packet_out[i].valid = live && !squash_from_retire_in && !reset;
            if (live && cur_taken[i]) begin
                blocked = 1'b1;
                next_pc = cur_target[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_reg;
        hold_load = 1'b0;
        if (squash_from_retire_in) begin
            state_nxt = S_FETCH;
            pc_nxt    = squashed_new_PC_in;
        end else begin
            case (state)
                S_FETCH: begin
                    if (Icache2proc_valid_in) begin
                        pc_nxt = next_pc;
                        if (stall) begin
                            hold_load = 1'b1;
                            state_nxt = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall)
                        state_nxt = S_FETCH;
                end
                default: state_nxt = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_FETCH;
            pc_reg <= '0;
        end else begin
            state  <= state_nxt;
            pc_reg <= pc_nxt;
        end
    end

    // Hold contents are only meaningful in S_HOLD, so they need no reset.
    always_ff @(posedge clock) begin
        if (hold_load) begin
            hold_data  <= Icache2proc_data_in;
            hold_taken <= bp_taken;
            hold_ofs   <= fetch_ofs;
            hold_base  <= fetch_base;
            for (int i = 0; i < FETCH_WIDTH; i++)
                hold_target[i] <= bp_target[i];
        end
    end
endmodule

// File: doc/ifetch_wide.md
# ifetch_wide

Parametrised N-wide instruction fetch stage, successor to the fixed 2-wide fetch. Each cycle it requests one aligned fetch block of FETCH_WIDTH instructions from the Icache. It masks lanes below a misaligned start PC and lanes after the first predicted-taken branch, then redirects the PC to the predicted target. A one-entry hold buffer captures a returned block when the instruction buffer stalls, so the Icache is never blocked. Sits between the Icache / branch predictor and the instruction buffer.

## Interface
- FETCH_WIDTH, 4: instructions per fetch block; power of 2, 2..8.
- BLOCK_BYTES, 4*FETCH_WIDTH: derived; fetch-block size in bytes.
- OFS_BITS, $clog2(FETCH_WIDTH): derived; lane-index width.
- clock  in  1  system clock. Single clock domain.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  instruction buffer cannot accept this cycle.
- squash_from_retire_in  in  1  redirect from retire.
- squashed_new_PC_in  in  `XLEN  redirect target; word-aligned.
- Icache2proc_valid_in  in  1  block data valid this cycle (hit).
- Icache2proc_data_in  in  32*FETCH_WIDTH  block; lane i = bits [32i+31:32i].
- bp_taken  in  FETCH_WIDTH  per-lane predicted taken, for the block at proc2Icache_addr_out.
- bp_target  in  [FETCH_WIDTH][`XLEN]  per-lane predicted target.
- proc2Icache_addr_out  out  `XLEN  block-aligned fetch address.
- proc2Icache_req_out  out  1  request valid.
- if_packet_out  out  IF_ID_PACKET [FETCH_WIDTH]  per-lane inst, PC, NPC, valid.

## Operation
- Registers: pc_reg (`XLEN), state {FETCH, HOLD}, hold buffer (data, bp_taken, bp_target, start offset).
- proc2Icache_addr_out = {pc_reg[`XLEN-1:OFS_BITS+2], zeros}.
- proc2Icache_req_out = (state==FETCH).
- ofs = pc_reg[OFS_BITS+1:2].
- Lane i is live iff all of:
  - the source is valid (FETCH: Icache2proc_valid_in; HOLD: 1);
  - i >= ofs;
  - no live lane j<i has bp_taken[j].
- Lane fields:
  - PC = block base + 4i.
  - NPC = bp_taken[i] ? bp_target[i] : PC+4.
  - inst taken from its data lane.
- valid[i] = live[i] & ~squash_from_retire_in.
- Block accepted = some lane valid & ~stall.
- Next PC when a block is produced (FETCH with Icache valid):
  - the target of the first live taken lane, if any;
  - otherwise block base + BLOCK_BYTES, with 32-bit wrap.
- FETCH transitions:
  - Icache valid & ~stall: pc_reg <= next PC; stay in FETCH.
  - Icache valid & stall: capture data, bp inputs and ofs into the hold buffer; pc_reg <= next PC; go to HOLD.
  - Icache invalid (miss): pc_reg unchanged, outputs invalid, stay in FETCH.
- HOLD:
  - Outputs are driven from the hold buffer and stay stable while stalled; the Icache is not requested.
  - ~stall: go to FETCH.
- Squash (priority over everything, any state):
  - pc_reg <= squashed_new_PC_in; state <= FETCH; hold buffer discarded.
  - All output valids are 0 in the squash cycle.
  - A squash PC with nonzero ofs produces a masked first block.

## Timing
- Reset values:
  - pc_reg = 0, state = FETCH, proc2Icache_req_out = 1, proc2Icache_addr_out = 0.
  - All if_packet_out.valid = 0 in the reset cycle.
- Icache is combinational-hit: addr out and data in are in the same cycle, and the packet is valid in that cycle.
- Miss: zero valids each cycle until hit; no PC change.
- Stall with Icache valid: the block appears in the same cycle; the next cycle holds it. The first ~stall cycle in HOLD consumes it, and a new fetch begins the cycle after.
- Stall without Icache valid: FETCH is retained.
- Squash with stall simultaneously: squash wins; the held block is dropped.
- Reset mid-HOLD: returns to reset values next cycle.
- Throughput: one block per cycle when there are no misses, stalls or squashes.

## Test plan
- W=4, reset, Icache always valid with data 0x10..0x13 per lane, no taken -> cycle 1: PCs 0,4,8,C all valid, NPCs 4,8,C,10; cycle 2 addr 0x10.
- Squash to 0x28 (W=4) -> next cycle addr 0x20, lanes 0,1 invalid, lanes 2,3 PC 0x28/0x2C valid; following addr 0x30.
- Block at 0x40, bp_taken=4'b0010, bp_target[1]=0x100 -> lanes 0,1 valid, lane 1 NPC 0x100, lanes 2,3 invalid; next addr 0x100.
- Icache valid with stall for 3 cycles -> packet stable for 3 cycles, req_out=0 in HOLD; stall drops -> same packet valid once, then the next block.
- Squash to 0x200 while in HOLD with stall=1 -> valids 0 that cycle; next cycle FETCH at addr 0x200, held block never reappears.
- Icache invalid for 5 cycles -> valids 0, addr constant; W=2 and W=8 builds repeat the first test with 0x8 / 0x20 block strides.
